// File: rtl/mult_div_if.sv
// ---------------------------------------------------------------------------
// mult_div_if
//   Request/response bundle between the execute stage and the iterative
//   multiply/divide engine.
//
//   Signals:
//     flush      cancel whatever operation is in flight
//     start      operation request, only looked at while the engine is idle
//     op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     operand_1  multiplicand / dividend
//     operand_2  multiplier / divisor
//     busy       engine is iterating
//     done       one-cycle completion pulse
//     result     {hi, lo}; product, or {remainder, quotient}
//
//   Modports:
//     master  execute stage side (drives the request)
//     slave   engine side (drives the response)
// ---------------------------------------------------------------------------
interface mult_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      flush;
    logic                      start;
    logic [1:0]                op;
    logic [DATA_WIDTH-1:0]     operand_1;
    logic [DATA_WIDTH-1:0]     operand_2;
    logic                      busy;
    logic                      done;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output flush, start, op, operand_1, operand_2,
        input  busy, done, result
    );

    modport slave (
        input  flush, start, op, operand_1, operand_2,
        output busy, done, result
    );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Radix-2 iterative multiply/divide engine for the execute stage.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract; both
//   run on magnitudes and fix the signs up on the last iteration.  With
//   MULT_FAST = 1 multiplies finish in a single cycle instead.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   mult_div_if.slave (flush/start/op/operands in, busy/done/result out)
//
//   Parameters:
//     DATA_WIDTH  operand width W (result is 2W bits)
//     MULT_FAST   1 = single-cycle multiply, 0 = W-cycle iterative multiply
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter bit MULT_FAST  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    mult_div_if.slave  bus
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);
    localparam logic [W-1:0]     ONE_W     = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] counter;
    logic             op_is_div;
    logic             sign_res;
    logic             sign_rem;
    logic [W-1:0]     acc_hi;
    logic [W-1:0]     acc_lo;
    logic [W-1:0]     operand_b;
    logic [2*W-1:0]   result_q;

    logic             busy_o;
    logic             done_o;

    logic             is_div_in;
    logic             is_signed_in;
    logic             neg_a;
    logic             neg_b;
    logic [W-1:0]     abs_a;
    logic [W-1:0]     abs_b;
    logic             div_by_zero_in;
    logic             fast_mul_in;
    logic [2*W-1:0]   fast_product;
    logic [2*W-1:0]   fast_result;

    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic             div_ge;
    logic [W-1:0]     iter_hi;
    logic [W-1:0]     iter_lo;
    logic [2*W-1:0]   mul_final;
    logic [2*W-1:0]   div_final;
    logic [2*W-1:0]   final_value;

    // Decode the incoming request while idle.  Only signed ops take
    // magnitudes; the most-negative value stays 2^(W-1) as an unsigned
    // magnitude, which is exactly what the datapath needs.
    always_comb begin
        is_div_in      = bus.op[1];
        is_signed_in   = ~bus.op[0];
        neg_a          = is_signed_in & bus.operand_1[W-1];
        neg_b          = is_signed_in & bus.operand_2[W-1];
        abs_a          = neg_a ? (~bus.operand_1 + ONE_W) : bus.operand_1;
        abs_b          = neg_b ? (~bus.operand_2 + ONE_W) : bus.operand_2;
        div_by_zero_in = (bus.operand_2 == '0);
        fast_mul_in    = MULT_FAST && !is_div_in;
        fast_product   = {{W{1'b0}}, abs_a} * {{W{1'b0}}, abs_b};
        fast_result    = (neg_a ^ neg_b) ? (~fast_product + (2*W)'(1)) : fast_product;
    end

    // One radix-2 step of whichever operation is latched.  For multiply,
    // acc_lo starts as the multiplier and drains out to the right while the
    // partial product grows into acc_hi.  For divide, acc_lo starts as the
    // dividend, shifts its top bit into the partial remainder in acc_hi and
    // fills with quotient bits from the bottom.  On the last step the
    // magnitudes are sign-corrected so the result register can be loaded
    // directly from this logic.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : {(W+1){1'b0}});
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, operand_b};
        div_ge    = (div_shift >= {1'b0, operand_b});

        if (op_is_div) begin
            iter_hi = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            iter_lo = {acc_lo[W-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[W:1];
            iter_lo = {mul_sum[0], acc_lo[W-1:1]};
        end

        mul_final = sign_res ? (~{iter_hi, iter_lo} + (2*W)'(1)) : {iter_hi, iter_lo};
        div_final = {(sign_rem ? (~iter_hi + ONE_W) : iter_hi),
                     (sign_res ? (~iter_lo + ONE_W) : iter_lo)};
        final_value = op_is_div ? div_final : mul_final;
    end

    // State register of the control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs.  Fast multiplies and divides by zero
    // skip BUSY since their result is ready at the sampling edge.  A flush
    // overrides everything, including a start in the same cycle, and also
    // suppresses a done pulse that would otherwise be shown.
    always_comb begin
        next_state = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (fast_mul_in || (is_div_in && div_by_zero_in)) begin
                        next_state = DONE;
                    end else begin
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                busy_o = 1'b1;
                if (counter == LAST_ITER) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (bus.flush) begin
            next_state = IDLE;
            done_o     = 1'b0;
        end
    end

    // Datapath registers.  Operands are captured once at start so later
    // changes on the bus have no effect.  result is only written when an
    // operation completes, so it holds across IDLE, new starts and flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            op_is_div <= 1'b0;
            sign_res  <= 1'b0;
            sign_rem  <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            result_q  <= '0;
        end else if (bus.flush) begin
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_is_div <= is_div_in;
                        sign_res  <= neg_a ^ neg_b;
                        sign_rem  <= neg_a;
                        acc_hi    <= '0;
                        acc_lo    <= is_div_in ? abs_a : abs_b;
                        operand_b <= is_div_in ? abs_b : abs_a;
                        counter   <= '0;
                        if (fast_mul_in) begin
                            result_q <= fast_result;
                        end else if (is_div_in && div_by_zero_in) begin
                            result_q <= {bus.operand_1, {W{1'b1}}};
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= iter_hi;
                    acc_lo <= iter_lo;
                    if (counter == LAST_ITER) begin
                        result_q <= final_value;
                        counter  <= '0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = busy_o;
    assign bus.done   = done_o;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit.  One iterative instance and one
//   fast-multiply instance share the clock and reset.  Expected results and
//   latencies are queued when a request is issued and popped when the
//   engine reports done.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        string       tag;
        logic [63:0] value;
        int          latency;
    } expect_t;

    logic clk;
    logic rst;

    mult_div_if #(.DATA_WIDTH(W)) sbus ();
    mult_div_if #(.DATA_WIDTH(W)) fbus ();

    mult_div_unit #(.DATA_WIDTH(W), .MULT_FAST(1'b0)) dut_slow (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    mult_div_unit #(.DATA_WIDTH(W), .MULT_FAST(1'b1)) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (fbus)
    );

    expect_t scoreboard[$];
    int      compared   = 0;
    int      mismatched = 0;

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backstop in case something blocks outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Drive one instance's request inputs.
    task automatic setInputs(input bit fast, input logic start, input logic flush,
                             input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        if (fast) begin
            fbus.start = start; fbus.flush = flush; fbus.op = op;
            fbus.operand_1 = a; fbus.operand_2 = b;
        end else begin
            sbus.start = start; sbus.flush = flush; sbus.op = op;
            sbus.operand_1 = a; sbus.operand_2 = b;
        end
    endtask

    // Pop the oldest expectation and compare it with what the engine shows
    // at the done cycle, then make sure done lasts exactly one cycle.
    task automatic collectResult(input bit fast, input int edges, input logic done_seen);
        expect_t e;
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboard_empty", 64'(scoreboard.size()), 64'd1);
            return;
        end
        e = scoreboard.pop_front();
        checkOutput({e.tag, "_done"}, {63'd0, done_seen}, 64'd1);
        checkOutput({e.tag, "_latency"}, 64'(edges), 64'(e.latency));
        checkOutput({e.tag, "_result"}, fast ? fbus.result : sbus.result, e.value);
        checkOutput({e.tag, "_busy_at_done"}, {63'd0, fast ? fbus.busy : sbus.busy}, 64'd0);
        @(posedge clk); #1;
        checkOutput({e.tag, "_done_one_cycle"}, {63'd0, fast ? fbus.done : sbus.done}, 64'd0);
    endtask

    // Issue one operation, scramble the request inputs after the sampling
    // edge (the engine must ignore them) and wait a bounded time for done.
    task automatic applyStimulus(input bit fast, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input string tag, input logic [63:0] value,
                                 input int latency);
        int   edges;
        logic done_seen;
        expect_t e;
        e.tag = tag; e.value = value; e.latency = latency;
        scoreboard.push_back(e);
        @(posedge clk); #1;
        setInputs(fast, 1'b1, 1'b0, op, a, b);
        @(posedge clk); #1;
        setInputs(fast, 1'b0, 1'b0, 2'($urandom), $urandom, $urandom);
        edges     = 0;
        done_seen = fast ? fbus.done : sbus.done;
        while (!done_seen && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            done_seen = fast ? fbus.done : sbus.done;
        end
        collectResult(fast, edges, done_seen);
    endtask

    initial begin
        int done_count;

        $display("[TB] mult_div_unit bench starting");
        rst = 1'b1;
        setInputs(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        setInputs(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);

        #2;
        checkOutput("reset_busy", {63'd0, sbus.busy}, 64'd0);
        checkOutput("reset_done", {63'd0, sbus.done}, 64'd0);
        checkOutput("reset_result", sbus.result, 64'd0);
        checkOutput("reset_fast_result", fbus.result, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Iterative multiplies and divides.
        applyStimulus(1'b0, OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, "mult_neg3x5",
                      64'hFFFF_FFFF_FFFF_FFF1, 32);
        applyStimulus(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max",
                      64'hFFFF_FFFE_0000_0001, 32);
        applyStimulus(1'b0, OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2",
                      64'hFFFF_FFFF_FFFF_FFFD, 32);
        applyStimulus(1'b0, OP_DIVU,  32'd100,       32'd7,         "divu_100_7",
                      64'h0000_0002_0000_000E, 32);
        applyStimulus(1'b0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_minint_m1",
                      64'h0000_0000_8000_0000, 32);
        applyStimulus(1'b0, OP_DIVU,  32'h0000_1234, 32'h0000_0000, "divu_by_zero",
                      64'h0000_1234_FFFF_FFFF, 0);
        applyStimulus(1'b0, OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, "div_neg_by_zero",
                      64'hFFFF_FFF9_FFFF_FFFF, 0);

        // Single-cycle multiply instance.
        applyStimulus(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "fast_multu_max",
                      64'hFFFF_FFFE_0000_0001, 0);
        applyStimulus(1'b1, OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, "fast_mult_neg3x5",
                      64'hFFFF_FFFF_FFFF_FFF1, 0);

        // Flush ten cycles into a divide: no done pulse, result untouched.
        @(posedge clk); #1;
        setInputs(1'b0, 1'b1, 1'b0, OP_DIVU, 32'd1000, 32'd3);
        @(posedge clk); #1;
        setInputs(1'b0, 1'b0, 1'b0, OP_DIVU, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("flush_busy_before", {63'd0, sbus.busy}, 64'd1);
        sbus.flush = 1'b1;
        @(posedge clk); #1;
        sbus.flush = 1'b0;
        checkOutput("flush_busy_after", {63'd0, sbus.busy}, 64'd0);
        checkOutput("flush_done_after", {63'd0, sbus.done}, 64'd0);
        done_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (sbus.done) done_count++;
        end
        checkOutput("flush_no_done_pulse", 64'(done_count), 64'd0);
        checkOutput("flush_result_kept", sbus.result, 64'hFFFF_FFF9_FFFF_FFFF);

        applyStimulus(1'b0, OP_MULTU, 32'd6, 32'd7, "multu_6x7_after_flush",
                      64'h0000_0000_0000_002A, 32);

        // start and flush together while idle: flush wins.
        @(posedge clk); #1;
        setInputs(1'b0, 1'b1, 1'b1, OP_MULTU, 32'd9, 32'd9);
        @(posedge clk); #1;
        setInputs(1'b0, 1'b0, 1'b0, OP_MULTU, 32'd9, 32'd9);
        checkOutput("start_flush_busy", {63'd0, sbus.busy}, 64'd0);
        checkOutput("start_flush_done", {63'd0, sbus.done}, 64'd0);
        @(posedge clk); #1;
        checkOutput("start_flush_still_idle", {63'd0, sbus.busy}, 64'd0);
        checkOutput("start_flush_result_kept", sbus.result, 64'h0000_0000_0000_002A);

        // Asynchronous reset between edges in the middle of a multiply.
        @(posedge clk); #1;
        setInputs(1'b0, 1'b1, 1'b0, OP_MULTU, 32'd3, 32'd3);
        @(posedge clk); #1;
        setInputs(1'b0, 1'b0, 1'b0, OP_MULTU, 32'd3, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        checkOutput("pre_reset_busy", {63'd0, sbus.busy}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_busy", {63'd0, sbus.busy}, 64'd0);
        checkOutput("async_reset_done", {63'd0, sbus.done}, 64'd0);
        checkOutput("async_reset_result", sbus.result, 64'd0);
        checkOutput("async_reset_fast_result", fbus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, OP_DIVU, 32'd100, 32'd7, "divu_after_reset",
                      64'h0000_0002_0000_000E, 32);

        checkOutput("scoreboard_drained", 64'(scoreboard.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide engine that supplies the execute stage's mult_div_done and mult_div_result.
- Handles MULT, MULTU, DIV and DIVU at DATA_WIDTH bits, using a radix-2 shift-add/subtract datapath. An optional single-cycle multiply path is available.
- The execute stage holds start high and stalls until done is asserted. A pipeline flush cancels any in-flight operation.

Parameters:
- DATA_WIDTH, 32, operand width W; result is 2W bits.
- MULT_FAST, 0, 1 = multiply completes in 1 cycle; 0 = multiply is iterative, W cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  cancel any in-flight operation (exception/branch flush).
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_1  in  W  multiplicand / dividend.
- operand_2  in  W  multiplier / divisor.
- busy  out  1  high in BUSY state.
- done  out  1  single-cycle completion pulse (DONE state).
- result  out  2W  {hi, lo}. Multiply: full product. Divide: hi = remainder, lo = quotient.

Behaviour:
- Reset (async, any state): state = IDLE, busy = 0, done = 0, result = 0, counter = 0, internal registers = 0.
- States: IDLE, BUSY, DONE.
  - IDLE + start + !flush: latch op, sign flags, and |operand_1|, |operand_2| (absolute values only for signed ops), plus sign_res and sign_rem.
    - Go to DONE instead of BUSY if op is a multiply and MULT_FAST = 1, or if op is a divide and operand_2 == 0.
    - Otherwise go to BUSY with counter = 0.
  - BUSY: one iteration per cycle; counter increments.
    - Multiply: conditional add of multiplicand into the upper half, then shift right.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
    - When counter == W-1, the final iteration's value is sign-corrected and registered into result; go to DONE.
  - DONE: done = 1 for exactly one cycle; unconditionally go to IDLE. start is ignored in DONE.
- Latency, counted in edges after the edge that sampled start:
  - Iterative op: done is high in the cycle after edge W (W = 32 gives 32 stall cycles).
  - Fast multiply and divide-by-zero: done is high in the cycle after edge 0.
- Sign rules:
  - Product is negated iff the operand signs differ (signed ops only).
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - Unsigned ops never negate.
- Arithmetic boundaries:
  - Signed most-negative / -1 gives quotient 0x80..0, remainder 0; no trap.
  - Absolute value of the most-negative operand is taken as unsigned 2^(W-1).
- Divide by zero (signed or unsigned): lo = all ones, hi = operand_1 as presented (raw); no exception raised.
- result holds its value from DONE until the next completion. It is not modified by a new start, by flush, or in IDLE.
- flush (any state, including the same cycle as start): next state = IDLE, done = 0, result unchanged, counter cleared. flush wins over start.
- busy and done are never high simultaneously.
- op or operand changes during BUSY are ignored; latched values are used.

Test Plan:
- MULT -3 × 5 (0xFFFFFFFD, 0x00000005), W = 32, MULT_FAST = 0 -> done pulse 32 cycles after start; result = 0xFFFFFFFF_FFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> result = 0xFFFFFFFE_00000001. Repeat with MULT_FAST = 1 -> done in the cycle after the start edge, same value.
- DIV -7 / 2 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFD. DIVU 100 / 7 -> hi = 0x00000002, lo = 0x0000000E. DIV 0x80000000 / 0xFFFFFFFF -> hi = 0, lo = 0x80000000.
- DIVU 0x1234 / 0 -> done after 1 cycle; hi = 0x00001234, lo = 0xFFFFFFFF.
- Start DIVU, assert flush at cycle 10 -> next cycle IDLE, no done pulse, result keeps its prior value. Then start MULTU 6 × 7 -> result = 0x0_0000002A after 32 cycles.
- Assert rst asynchronously mid-BUSY (between edges) -> busy, done and result are 0 immediately. Also check start and flush in the same IDLE cycle -> stays IDLE, busy stays 0.
